// File: rtl/tcu_pkg.sv
// -----------------------------------------------------------------------------
// tcu_pkg
//   Shared definitions for the TCU micro-op sequencer:
//     - source/destination format id constants and fmt_supported()
//     - tile geometry helpers parameterised by thread count (nt),
//       registers per tile (nr) and dot-product depth override (dp)
//     - base register indices RA/RB/RC
//     - sequencer state enum and the fixed-width part of a micro-op
// -----------------------------------------------------------------------------
package tcu_pkg;

    // Format ids accepted by the datapath
    localparam logic [3:0] TCU_FMT_FP32 = 4'd0;
    localparam logic [3:0] TCU_FMT_FP16 = 4'd1;
    localparam logic [3:0] TCU_FMT_BF16 = 4'd2;
    localparam logic [3:0] TCU_FMT_FP8  = 4'd3;
    localparam logic [3:0] TCU_FMT_I32  = 4'd8;
    localparam logic [3:0] TCU_FMT_I8   = 4'd9;
    localparam logic [3:0] TCU_FMT_U8   = 4'd10;
    localparam logic [3:0] TCU_FMT_I4   = 4'd11;
    localparam logic [3:0] TCU_FMT_U4   = 4'd12;

    localparam int TCU_RA = 0;

    typedef enum logic {
        TCU_SEQ_IDLE = 1'b0,
        TCU_SEQ_RUN  = 1'b1
    } tcu_seq_state_e;

    // Parameter-independent fields of one micro-op
    typedef struct packed {
        logic [3:0] fmt_s;
        logic [3:0] fmt_d;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       first;
        logic       last;
    } tcu_uop_t;

    function automatic logic fmt_supported(input logic [3:0] fmt);
        case (fmt)
            TCU_FMT_FP32, TCU_FMT_FP16, TCU_FMT_BF16, TCU_FMT_FP8,
            TCU_FMT_I32, TCU_FMT_I8, TCU_FMT_U8, TCU_FMT_I4, TCU_FMT_U4:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    // Index width for a counter of n values, never narrower than one bit
    function automatic int tcu_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tcu_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Whole tile: nt*nr elements split as square as possible, M taking the odd bit
    function automatic int tcu_tile_m(input int nt, input int nr);
        return 1 << (($clog2(nt * nr) + 1) / 2);
    endfunction

    function automatic int tcu_tile_n(input int nt, input int nr);
        return 1 << ($clog2(nt * nr) / 2);
    endfunction

    function automatic int tcu_tile_k(input int nt, input int nr);
        return (nt * nr) / tcu_max(tcu_tile_m(nt, nr), tcu_tile_n(nt, nr));
    endfunction

    // One step: the nt lanes cover a tc_m x tc_n block
    function automatic int tcu_tc_m(input int nt);
        return 1 << (($clog2(nt) + 1) / 2);
    endfunction

    function automatic int tcu_tc_n(input int nt);
        return 1 << ($clog2(nt) / 2);
    endfunction

    function automatic int tcu_tc_k(input int nt, input int dp);
        return (dp != 0) ? dp : nt / tcu_max(tcu_tc_m(nt), tcu_tc_n(nt));
    endfunction

    function automatic int tcu_m_steps(input int nt, input int nr);
        return tcu_max(tcu_tile_m(nt, nr) / tcu_tc_m(nt), 1);
    endfunction

    function automatic int tcu_n_steps(input int nt, input int nr);
        return tcu_max(tcu_tile_n(nt, nr) / tcu_tc_n(nt), 1);
    endfunction

    function automatic int tcu_k_steps(input int nt, input int nr, input int dp);
        return tcu_max(tcu_tile_k(nt, nr) / tcu_tc_k(nt, dp), 1);
    endfunction

    // How many B step-blocks share one register
    function automatic int tcu_b_sub_blocks(input int nt, input int dp);
        return tcu_max(nt / (tcu_tc_k(nt, dp) * tcu_tc_n(nt)), 1);
    endfunction

    function automatic int tcu_nrb(input int nt, input int nr);
        return (tcu_tile_n(nt, nr) * tcu_tile_k(nt, nr)) / nt;
    endfunction

    function automatic int tcu_rb(input int nt, input int nr);
        return (tcu_nrb(nt, nr) == 4) ? 28 : 10;
    endfunction

    function automatic int tcu_rc(input int nt, input int nr);
        return (tcu_nrb(nt, nr) == 4) ? 10 : 24;
    endfunction

endpackage

// File: rtl/tcu_step_counter.sv
// -----------------------------------------------------------------------------
// tcu_step_counter
//   Three-level nested m/n/k counter with selectable loop order.
//   Ports:
//     clk_i, reset_i   clock, synchronous active-high reset
//     clear_i          force all indices to zero (new instruction)
//     adv_i            advance one step (micro-op completed)
//     k_outer_i        0: k fastest, then n, then m; 1: n fastest, then m, then k
//     m_o, n_o, k_o    current indices
//     last_o           every index is at its final value
// -----------------------------------------------------------------------------
module tcu_step_counter #(
    parameter int M_N = 2,
    parameter int N_N = 4,
    parameter int K_N = 4,
    parameter int M_W = 1,
    parameter int N_W = 2,
    parameter int K_W = 2
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           clear_i,
    input  logic           adv_i,
    input  logic           k_outer_i,
    output logic [M_W-1:0] m_o,
    output logic [N_W-1:0] n_o,
    output logic [K_W-1:0] k_o,
    output logic           last_o
);

    logic [M_W-1:0] m_q, m_d;
    logic [N_W-1:0] n_q, n_d;
    logic [K_W-1:0] k_q, k_d;
    logic           m_end, n_end, k_end;

    assign m_end = (m_q == M_W'(M_N - 1));
    assign n_end = (n_q == N_W'(N_N - 1));
    assign k_end = (k_q == K_W'(K_N - 1));

    always_comb begin
        m_d = m_q;
        n_d = n_q;
        k_d = k_q;
        if (clear_i) begin
            m_d = '0;
            n_d = '0;
            k_d = '0;
        end else if (adv_i) begin
            if (!k_outer_i) begin
                k_d = k_end ? '0 : k_q + K_W'(1);
                if (k_end) begin
                    n_d = n_end ? '0 : n_q + N_W'(1);
                    if (n_end) begin
                        m_d = m_end ? '0 : m_q + M_W'(1);
                    end
                end
            end else begin
                n_d = n_end ? '0 : n_q + N_W'(1);
                if (n_end) begin
                    m_d = m_end ? '0 : m_q + M_W'(1);
                    if (m_end) begin
                        k_d = k_end ? '0 : k_q + K_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_q <= '0;
            n_q <= '0;
            k_q <= '0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
            k_q <= k_d;
        end
    end

    assign m_o    = m_q;
    assign n_o    = n_q;
    assign k_o    = k_q;
    assign last_o = m_end & n_end & k_end;

endmodule

// File: rtl/tcu_uop_seq.sv
// -----------------------------------------------------------------------------
// tcu_uop_seq
//   Expands one accepted WMMA instruction into M_STEPS*N_STEPS*K_STEPS TCU
//   micro-ops carrying step indices, A/B/C register indices and first/last.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     in_valid/in_ready     instruction handshake (in_ready only while idle)
//     in_uuid, in_wid, in_fmt_s, in_fmt_d, in_k_outer   instruction fields
//     out_valid/out_ready   micro-op handshake
//     out_*                 micro-op payload (all zero while idle)
//     fmt_err               one-cycle pulse after an unsupported format is dropped
//     busy                  a sequence is in progress
//   Optional (macro TCU_UOP_SEQ_PERF_EN): perf_instrs, perf_stalls counters.
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   While out_valid is high and out_ready low, every out_* field holds.
// -----------------------------------------------------------------------------
module tcu_uop_seq
    import tcu_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int NUM_REGS    = 8,
    parameter int DP          = 0,
    parameter int UUID_WIDTH  = 44,
    parameter int WID_WIDTH   = 2,
    localparam int M_STEPS = tcu_m_steps(NUM_THREADS, NUM_REGS),
    localparam int N_STEPS = tcu_n_steps(NUM_THREADS, NUM_REGS),
    localparam int K_STEPS = tcu_k_steps(NUM_THREADS, NUM_REGS, DP),
    localparam int B_SUB_BLOCKS = tcu_b_sub_blocks(NUM_THREADS, DP),
    localparam int SM_W = tcu_idx_w(M_STEPS),
    localparam int SN_W = tcu_idx_w(N_STEPS),
    localparam int SK_W = tcu_idx_w(K_STEPS),
    localparam int BS_W = tcu_idx_w(B_SUB_BLOCKS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [UUID_WIDTH-1:0] in_uuid,
    input  logic [WID_WIDTH-1:0]  in_wid,
    input  logic [3:0]            in_fmt_s,
    input  logic [3:0]            in_fmt_d,
    input  logic                  in_k_outer,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [UUID_WIDTH-1:0] out_uuid,
    output logic [WID_WIDTH-1:0]  out_wid,
    output logic [3:0]            out_fmt_s,
    output logic [3:0]            out_fmt_d,
    output logic [SM_W-1:0]       out_step_m,
    output logic [SN_W-1:0]       out_step_n,
    output logic [SK_W-1:0]       out_step_k,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [BS_W-1:0]       out_b_sub,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  fmt_err,
    output logic                  busy
`ifdef TCU_UOP_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_instrs,
    output logic [31:0]           perf_stalls
`endif
);

    localparam int RB   = tcu_rb(NUM_THREADS, NUM_REGS);
    localparam int RC   = tcu_rc(NUM_THREADS, NUM_REGS);
    localparam int BL_W = tcu_idx_w(N_STEPS * K_STEPS);

    tcu_seq_state_e        state_q, state_d;
    logic                  fmt_err_q, fmt_err_d;
    logic [UUID_WIDTH-1:0] uuid_q;
    logic [WID_WIDTH-1:0]  wid_q;
    logic [3:0]            fmt_s_q, fmt_d_q;
    logic                  k_outer_q;

    logic                  fmt_ok, start, fire;
    logic [SM_W-1:0]       m_idx;
    logic [SN_W-1:0]       n_idx;
    logic [SK_W-1:0]       k_idx;
    logic                  cnt_last;
    logic [BL_W-1:0]       b_lin;
    tcu_uop_t              uop;

    assign fmt_ok = fmt_supported(in_fmt_s) & fmt_supported(in_fmt_d);
    // Only a supported instruction starts a sequence; a rejected one is still consumed
    assign start  = in_valid && (state_q == TCU_SEQ_IDLE) && fmt_ok;
    assign fire   = (state_q == TCU_SEQ_RUN) && out_ready;

    always_comb begin
        state_d   = state_q;
        fmt_err_d = 1'b0;
        case (state_q)
            TCU_SEQ_IDLE: begin
                if (in_valid) begin
                    if (fmt_ok) state_d   = TCU_SEQ_RUN;
                    else        fmt_err_d = 1'b1;
                end
            end
            TCU_SEQ_RUN: begin
                if (out_ready && cnt_last) state_d = TCU_SEQ_IDLE;
            end
            default: state_d = TCU_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TCU_SEQ_IDLE;
            fmt_err_q <= 1'b0;
            uuid_q    <= '0;
            wid_q     <= '0;
            fmt_s_q   <= '0;
            fmt_d_q   <= '0;
            k_outer_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fmt_err_q <= fmt_err_d;
            if (start) begin
                uuid_q    <= in_uuid;
                wid_q     <= in_wid;
                fmt_s_q   <= in_fmt_s;
                fmt_d_q   <= in_fmt_d;
                k_outer_q <= in_k_outer;
            end
        end
    end

    tcu_step_counter #(
        .M_N (M_STEPS),
        .N_N (N_STEPS),
        .K_N (K_STEPS),
        .M_W (SM_W),
        .N_W (SN_W),
        .K_W (SK_W)
    ) u_cnt (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (start),
        .adv_i     (fire),
        .k_outer_i (k_outer_q),
        .m_o       (m_idx),
        .n_o       (n_idx),
        .k_o       (k_idx),
        .last_o    (cnt_last)
    );

    // Register indices wrap modulo 32, so 5-bit arithmetic is exact.
    // The B index is linearised over (n,k) before splitting into register/sub-block.
    always_comb begin
        uop   = '0;
        b_lin = BL_W'(n_idx) * BL_W'(K_STEPS) + BL_W'(k_idx);
        if (state_q == TCU_SEQ_RUN) begin
            uop.fmt_s = fmt_s_q;
            uop.fmt_d = fmt_d_q;
            uop.rs1   = 5'(TCU_RA) + 5'(m_idx) * 5'(K_STEPS) + 5'(k_idx);
            uop.rs2   = 5'(RB) + 5'(32'(b_lin) / 32'(B_SUB_BLOCKS));
            uop.rd    = 5'(RC) + 5'(m_idx) * 5'(N_STEPS) + 5'(n_idx);
            // All-zero indices occur exactly once per sequence in either loop order
            uop.first = (m_idx == '0) && (n_idx == '0) && (k_idx == '0);
            uop.last  = cnt_last;
        end
    end

    assign in_ready   = (state_q == TCU_SEQ_IDLE);
    assign busy       = (state_q == TCU_SEQ_RUN);
    assign out_valid  = busy;
    assign fmt_err    = fmt_err_q;
    assign out_uuid   = busy ? uuid_q : '0;
    assign out_wid    = busy ? wid_q : '0;
    assign out_fmt_s  = uop.fmt_s;
    assign out_fmt_d  = uop.fmt_d;
    // Counters sit at zero whenever idle, so the steps need no gating
    assign out_step_m = m_idx;
    assign out_step_n = n_idx;
    assign out_step_k = k_idx;
    assign out_rs1    = uop.rs1;
    assign out_rs2    = uop.rs2;
    assign out_rd     = uop.rd;
    assign out_b_sub  = busy ? BS_W'(32'(b_lin) % 32'(B_SUB_BLOCKS)) : '0;
    assign out_first  = uop.first;
    assign out_last   = uop.last;

`ifdef TCU_UOP_SEQ_PERF_EN
    logic [31:0] perf_instrs_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instrs_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (start)                   perf_instrs_q <= perf_instrs_q + 32'd1;
            if (out_valid && !out_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_instrs = perf_instrs_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_tcu_uop_seq.sv
module tb_tcu_uop_seq;

  localparam int TB_NT = 8;
  localparam int TB_NR = 8;

  // Expected geometry for the supported bench configurations (NR = 8)
  localparam int EXP_MS = (TB_NT == 4) ? 4 : 2;
  localparam int EXP_NS = (TB_NT == 4) ? 2 : 4;
  localparam int EXP_KS = (TB_NT == 4) ? 2 : 4;
  localparam int EXP_BS = (TB_NT == 4) ? 1 : 2;
  localparam int EXP_RA = 0;
  localparam int EXP_RB = (TB_NT == 4) ? 28 : 10;
  localparam int EXP_RC = (TB_NT == 4) ? 10 : 24;
  localparam int UOPS   = EXP_MS * EXP_NS * EXP_KS;
  localparam int SM_W   = (EXP_MS > 1) ? $clog2(EXP_MS) : 1;
  localparam int SN_W   = (EXP_NS > 1) ? $clog2(EXP_NS) : 1;
  localparam int SK_W   = (EXP_KS > 1) ? $clog2(EXP_KS) : 1;
  localparam int BS_W   = (EXP_BS > 1) ? $clog2(EXP_BS) : 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            in_valid, in_ready;
  logic [43:0]     in_uuid;
  logic [1:0]      in_wid;
  logic [3:0]      in_fmt_s, in_fmt_d;
  logic            in_k_outer;
  logic            out_valid, out_ready;
  logic [43:0]     out_uuid;
  logic [1:0]      out_wid;
  logic [3:0]      out_fmt_s, out_fmt_d;
  logic [SM_W-1:0] out_step_m;
  logic [SN_W-1:0] out_step_n;
  logic [SK_W-1:0] out_step_k;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [BS_W-1:0] out_b_sub;
  logic            out_first, out_last;
  logic            fmt_err, busy;
`ifdef TCU_UOP_SEQ_PERF_EN
  logic [31:0]     perf_instrs, perf_stalls;
`endif

  tcu_uop_seq #(
    .NUM_THREADS (TB_NT),
    .NUM_REGS    (TB_NR),
    .DP          (0),
    .UUID_WIDTH  (44),
    .WID_WIDTH   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_uuid    (in_uuid),
    .in_wid     (in_wid),
    .in_fmt_s   (in_fmt_s),
    .in_fmt_d   (in_fmt_d),
    .in_k_outer (in_k_outer),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_uuid   (out_uuid),
    .out_wid    (out_wid),
    .out_fmt_s  (out_fmt_s),
    .out_fmt_d  (out_fmt_d),
    .out_step_m (out_step_m),
    .out_step_n (out_step_n),
    .out_step_k (out_step_k),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_b_sub  (out_b_sub),
    .out_first  (out_first),
    .out_last   (out_last),
    .fmt_err    (fmt_err),
    .busy       (busy)
`ifdef TCU_UOP_SEQ_PERF_EN
    ,
    .perf_instrs (perf_instrs),
    .perf_stalls (perf_stalls)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_instrs = 0;
  int exp_stalls = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_uop(input int m, input int n, input int k,
                                           input int rs1, input int rs2, input int bsub,
                                           input int rd, input bit first, input bit last,
                                           input logic [7:0] uid, input logic [1:0] wid,
                                           input logic [3:0] fs, input logic [3:0] fd);
    return {15'd0, uid, wid, fs, fd, 4'(m), 4'(n), 4'(k), 5'(rs1), 5'(rs2),
            2'(bsub), 5'(rd), first, last};
  endfunction

  function automatic logic [63:0] observed();
    return pack_uop(int'(out_step_m), int'(out_step_n), int'(out_step_k),
                    int'(out_rs1), int'(out_rs2), int'(out_b_sub), int'(out_rd),
                    out_first, out_last, out_uuid[7:0], out_wid, out_fmt_s, out_fmt_d);
  endfunction

  // Reference model: enumerate micro-ops in loop order and push them
  task automatic push_model(input bit ko, input logic [7:0] uid, input logic [1:0] wid,
                            input logic [3:0] fs, input logic [3:0] fd);
    int idx = 0;
    for (int a = 0; a < EXP_MS * EXP_NS * EXP_KS; a++) begin
      int m, n, k, lin;
      if (!ko) begin
        k = a % EXP_KS; n = (a / EXP_KS) % EXP_NS; m = a / (EXP_KS * EXP_NS);
      end else begin
        n = a % EXP_NS; m = (a / EXP_NS) % EXP_MS; k = a / (EXP_NS * EXP_MS);
      end
      lin = n * EXP_KS + k;
      exp_q.push_back(pack_uop(m, n, k,
                               (EXP_RA + m * EXP_KS + k) % 32,
                               (EXP_RB + lin / EXP_BS) % 32,
                               lin % EXP_BS,
                               (EXP_RC + m * EXP_NS + n) % 32,
                               idx == 0, idx == UOPS - 1, uid, wid, fs, fd));
      idx++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_instrs = 0;
    exp_stalls = 0;
  endtask

  // Issues one instruction and drains up to max_hs micro-ops.
  // ready_pct sets the out_ready probability per cycle.
  task automatic run_instr(input bit ko, input logic [3:0] fs, input logic [3:0] fd,
                           input int ready_pct, input int max_hs);
    logic [43:0] uid;
    logic [1:0]  wid;
    int done = 0;
    bit r;
    uid = 44'({$urandom(), $urandom()});
    wid = 2'($urandom_range(3));
    @(negedge clk);
    in_valid = 1'b1; in_uuid = uid; in_wid = wid;
    in_fmt_s = fs; in_fmt_d = fd; in_k_outer = ko;
    push_model(ko, uid[7:0], wid, fs, fd);
    exp_instrs++;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    while (exp_q.size() > 0 && done < max_hs) begin
      check("out_valid_run", out_valid, 1);
      check("in_ready_run", in_ready, 0);
      check("payload", observed(), exp_q[0]);
      r = ($urandom_range(99) < ready_pct);
      out_ready = r;
      if (r) begin
        void'(exp_q.pop_front());
        done++;
      end else begin
        exp_stalls++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (exp_q.size() == 0) begin
      check("out_valid_end", out_valid, 0);
      check("in_ready_end", in_ready, 1);
      check("busy_end", busy, 0);
      check("idle_payload", observed(), 64'd0);
    end
  endtask

  task automatic bad_fmt(input logic [3:0] fs, input logic [3:0] fd);
    @(negedge clk);
    in_valid = 1'b1; in_fmt_s = fs; in_fmt_d = fd; in_k_outer = 1'b0;
    in_uuid = 44'h123; in_wid = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check("fmt_err_pulse", fmt_err, 1);
    check("fmt_out_valid", out_valid, 0);
    check("fmt_in_ready", in_ready, 1);
    @(negedge clk);
    check("fmt_err_clear", fmt_err, 0);
    check("fmt_out_valid2", out_valid, 0);
    check("fmt_busy", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_uuid = '0; in_wid = '0;
    in_fmt_s = '0; in_fmt_d = '0; in_k_outer = 1'b0; out_ready = 1'b0;

    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fmt_err", fmt_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_payload", observed(), 64'd0);

    // Unsupported source and destination formats are swallowed
    bad_fmt(4'd5, 4'd0);
    bad_fmt(4'd1, 4'd13);

    // Full-rate sequences in both loop orders, several formats
    run_instr(1'b0, 4'd0, 4'd0, 100, UOPS);
    run_instr(1'b1, 4'd1, 4'd0, 100, UOPS);
    run_instr(1'b0, 4'd9, 4'd8, 100, UOPS);

    // Random backpressure in both orders
    run_instr(1'b0, 4'd2, 4'd12, 50, UOPS);
    run_instr(1'b1, 4'd11, 4'd10, 50, UOPS);

    // Abort after ten completed micro-ops
    run_instr(1'b0, 4'd3, 4'd0, 100, 10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    reset = 1'b0;
    exp_q.delete();
    exp_instrs = 0;
    exp_stalls = 0;
    @(negedge clk);
    check("abort_quiet", out_valid, 0);

    // Restart after abort, with backpressure so stalls accumulate
    run_instr(1'b1, 4'd0, 4'd1, 50, UOPS);

`ifdef TCU_UOP_SEQ_PERF_EN
    check("perf_instrs", perf_instrs, 64'(exp_instrs));
    check("perf_stalls", perf_stalls, 64'(exp_stalls));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
